fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction memory and feeds the decode stage. It owns the PC and drives the word address into the synchronous instruction memory, which has a one-cycle read latency and no enable. It pairs each returned instruction word with its PC and presents it to decode over a valid/ready handshake. It absorbs decode stalls with a one-entry hold buffer so that no bubble is lost, and it squashes and redirects on branches, jumps and traps.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input
// and the valid/ready handshake toward decode.
//   master : fetch unit side (drives imem_addr and the if_* outputs)
//   slave  : environment side (memory, redirect source, decode)
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  modport master (
    output imem_addr, if_valid, if_pc, if_instr,
    input  imem_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_pc, if_instr,
    output imem_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, addresses a synchronous instruction
// memory (one-cycle latency, no enable), pairs each returned word with its PC
// and hands it to decode over valid/ready. A one-entry hold buffer absorbs
// decode stalls; redirects squash the current output and restart fetch.
//
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   bus (master)     : imem_addr/imem_data, redirect_valid/redirect_pc,
//                      id_ready, if_valid/if_pc/if_instr
//   perf_fetch_cnt   : transfers to decode        (FETCH_PERF_EN only)
//   perf_stall_cnt   : cycles valid but not ready (FETCH_PERF_EN only)
//
// Optional feature macro: FETCH_PERF_EN adds the two performance counters.
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  fetch_unit_if.master bus
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] BOOT_PC    = RESET_PC & ALIGN_MASK;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    STREAM = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] req_pc, req_pc_d;
  logic [XLEN-1:0] hold_pc, hold_pc_d;
  logic [XLEN-1:0] hold_instr, hold_instr_d;
  logic [XLEN-1:0] redirect_aligned;
  logic [XLEN-1:0] req_pc_inc;

  assign redirect_aligned = bus.redirect_pc & ALIGN_MASK;
  // Wraps modulo 2^XLEN by construction.
  assign req_pc_inc       = req_pc + XLEN'(4);

  // State and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      req_pc     <= BOOT_PC;
      hold_pc    <= '0;
      hold_instr <= '0;
    end else begin
      state      <= state_d;
      req_pc     <= req_pc_d;
      hold_pc    <= hold_pc_d;
      hold_instr <= hold_instr_d;
    end
  end

  // Next state, memory address and decode-facing outputs.
  always_comb begin
    state_d      = state;
    req_pc_d     = req_pc;
    hold_pc_d    = hold_pc;
    hold_instr_d = hold_instr;
    bus.imem_addr = req_pc;
    bus.if_valid  = 1'b0;
    bus.if_pc     = '0;
    bus.if_instr  = NOP_INSTR;

    if (bus.redirect_valid) begin
      // Squash whatever is presented and start fetching the target now.
      bus.imem_addr = redirect_aligned;
      req_pc_d      = redirect_aligned;
      hold_pc_d     = '0;
      hold_instr_d  = '0;
      state_d       = STREAM;
    end else begin
      unique case (state)
        BOOT: begin
          bus.imem_addr = BOOT_PC;
          req_pc_d      = BOOT_PC;
          state_d       = STREAM;
        end
        STREAM: begin
          bus.if_valid  = 1'b1;
          bus.if_pc     = req_pc;
          bus.if_instr  = bus.imem_data;
          bus.imem_addr = req_pc_inc;
          req_pc_d      = req_pc_inc;
          if (!bus.id_ready) begin
            // Capture the word now; the memory moves on to req_pc+4, which
            // HOLD keeps re-addressing so it is ready when decode frees up.
            hold_pc_d    = req_pc;
            hold_instr_d = bus.imem_data;
            state_d      = HOLD;
          end
        end
        HOLD: begin
          bus.if_valid = 1'b1;
          bus.if_pc    = hold_pc;
          bus.if_instr = hold_instr;
          if (bus.id_ready) begin
            state_d = STREAM;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Redirect cycles never count since if_valid is forced low there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (bus.if_valid && bus.id_ready) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (bus.if_valid && !bus.id_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. The instruction memory returns the word
// index of the address (word[i] = i) one cycle after the address is presented.
module tb_fetch_unit;
  localparam int unsigned XLEN = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .bus           (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory, one-cycle latency, no enable.
  always_ff @(posedge clk) begin
    bus.imem_data <= {2'b00, bus.imem_addr[31:2]};
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then wait for the falling edge.
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    bus.id_ready       = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(negedge clk);
  endtask

  task automatic expect_valid(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, "_valid"}, 32'(bus.if_valid), 32'd1);
    check({tag, "_pc"}, bus.if_pc, pc);
    check({tag, "_instr"}, bus.if_instr, instr);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 32'(bus.if_valid), 32'd0);
    check({tag, "_pc"}, bus.if_pc, 32'h0);
    check({tag, "_instr"}, bus.if_instr, 32'h0000_0013);
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    rst                = 1'b1;
    bus.imem_data      = '0;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    @(negedge clk);
    expect_idle("reset");
`ifdef FETCH_PERF_EN
    check("reset_fetch_cnt", perf_fetch_cnt, 32'd0);
    check("reset_stall_cnt", perf_stall_cnt, 32'd0);
`endif

    // Cycle 1 after release: BOOT, nothing valid yet.
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    expect_idle("boot");
    check("boot_addr", bus.imem_addr, 32'h0);

    // Streaming from the reset PC.
    drive(1'b1, 1'b0, 32'h0); expect_valid("s0", 32'h0, 32'd0);
    drive(1'b1, 1'b0, 32'h0); expect_valid("s4", 32'h4, 32'd1);
    // Decode stalls for three cycles while pc 0x8 is presented.
    drive(1'b0, 1'b0, 32'h0); expect_valid("st8_0", 32'h8, 32'd2);
    drive(1'b0, 1'b0, 32'h0); expect_valid("st8_1", 32'h8, 32'd2);
    check("hold_addr", bus.imem_addr, 32'hC);
    drive(1'b0, 1'b0, 32'h0); expect_valid("st8_2", 32'h8, 32'd2);
    drive(1'b1, 1'b0, 32'h0); expect_valid("st8_3", 32'h8, 32'd2);
    drive(1'b1, 1'b0, 32'h0); expect_valid("sC", 32'hC, 32'd3);
    drive(1'b1, 1'b0, 32'h0); expect_valid("s10", 32'h10, 32'd4);

    // Stall at 0x14, then redirect to 0x43 while holding.
    drive(1'b0, 1'b0, 32'h0); expect_valid("st14", 32'h14, 32'd5);
`ifdef FETCH_PERF_EN
    check("perf_fetch5", perf_fetch_cnt, 32'd5);
    check("perf_stall3", perf_stall_cnt, 32'd3);
`endif
    drive(1'b0, 1'b1, 32'h43); expect_idle("redir_hold");
    check("redir_addr", bus.imem_addr, 32'h40);
    drive(1'b1, 1'b0, 32'h0); expect_valid("r40", 32'h40, 32'd16);
    drive(1'b1, 1'b0, 32'h0); expect_valid("r44", 32'h44, 32'd17);
`ifdef FETCH_PERF_EN
    // Stall at 0x14 counts, the redirect cycle does not; 0x40 transferred.
    check("perf_fetch6", perf_fetch_cnt, 32'd6);
    check("perf_stall4", perf_stall_cnt, 32'd4);
`endif

    // Back-to-back redirects: last one wins.
    drive(1'b1, 1'b1, 32'h200); expect_idle("redir_a");
    drive(1'b1, 1'b1, 32'hFFFF_FFFE); expect_idle("redir_b");
    check("redir_b_addr", bus.imem_addr, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 32'h0); expect_valid("wFFC", 32'hFFFF_FFFC, 32'h3FFF_FFFF);
    drive(1'b1, 1'b0, 32'h0); expect_valid("w000", 32'h0, 32'd0);
    drive(1'b1, 1'b0, 32'h0); expect_valid("w004", 32'h4, 32'd1);

    // Enter HOLD, then reset asynchronously between edges.
    drive(1'b0, 1'b0, 32'h0); expect_valid("h8_0", 32'h8, 32'd2);
    drive(1'b0, 1'b0, 32'h0); expect_valid("h8_1", 32'h8, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    expect_idle("async_rst");
`ifdef FETCH_PERF_EN
    check("rst_fetch_cnt", perf_fetch_cnt, 32'd0);
    check("rst_stall_cnt", perf_stall_cnt, 32'd0);
`endif

    // Redirect in the first cycle after release: reset PC never shown valid.
    @(posedge clk);
    #1;
    rst                = 1'b0;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    @(negedge clk);
    expect_idle("boot_redir");
    check("boot_redir_addr", bus.imem_addr, 32'h100);
    drive(1'b1, 1'b0, 32'h0); expect_valid("b100", 32'h100, 32'h40);
    drive(1'b1, 1'b0, 32'h0); expect_valid("b104", 32'h104, 32'h41);
`ifdef FETCH_PERF_EN
    check("post_rst_fetch", perf_fetch_cnt, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
